// File: rtl/snn_soc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : snn_soc_pkg
// Description : Shared constants and types for the SNN SoC datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package snn_soc_pkg;

  // Number of wordlines driven by the DAC (one pixel per wordline)
  localparam int NUM_INPUTS = 16;

  // Bits per pixel, and therefore the maximum number of bit-planes per frame
  localparam int PIXEL_BITS = 8;

  // Default watchdog limit for one bit-plane timestep
  localparam int ENC_TIMEOUT_CYCLES = 1024;

  // Bit-plane encoder control states
  typedef enum logic [0:0] {
    ENC_IDLE = 1'b0,
    ENC_WAIT = 1'b1
  } enc_state_t;

endpackage : snn_soc_pkg
`default_nettype wire

// File: rtl/input_pixel_buf.sv
`default_nettype none
// ============================================================================
// Module      : input_pixel_buf
// Description : NUM_INPUTS x PIXEL_BITS pixel store with one write port and a
//               combinational bit-plane select output.
// Revision    : 1.0 - initial release
// ============================================================================
module input_pixel_buf #(
  parameter int NUM_INPUTS = 16,
  parameter int PIXEL_BITS = 8,
  parameter int AW         = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1,
  parameter int PW         = (PIXEL_BITS > 1) ? $clog2(PIXEL_BITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we_i,
  input  logic [AW-1:0]         addr_i,
  input  logic [PIXEL_BITS-1:0] wdata_i,
  input  logic [PW-1:0]         plane_sel_i,
  output logic [NUM_INPUTS-1:0] bitmap_o
);

  logic [PIXEL_BITS-1:0] mem_q [NUM_INPUTS];

  // Pixel storage; out-of-range addresses are silently discarded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i && (int'(addr_i) < NUM_INPUTS)) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Bit-plane select: bit plane_sel_i of every stored pixel
  for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_bitmap
    assign bitmap_o[gi] = mem_q[gi][plane_sel_i];
  end

endmodule : input_pixel_buf
`default_nettype wire

// File: rtl/bitplane_encoder.sv
`default_nettype none
// ============================================================================
// Module      : bitplane_encoder
// Description : Holds one pixel vector and issues it MSB-first, one bit-plane
//               per timestep, handshaking with the core sequencer and
//               aborting the frame if a timestep never completes.
// Revision    : 1.0 - initial release
// ============================================================================
module bitplane_encoder
  import snn_soc_pkg::*;
#(
  parameter int NUM_INPUTS     = snn_soc_pkg::NUM_INPUTS,
  parameter int PIXEL_BITS     = snn_soc_pkg::PIXEL_BITS,
  parameter int TIMEOUT_CYCLES = snn_soc_pkg::ENC_TIMEOUT_CYCLES
) (
  input  logic                                                  clk,
  input  logic                                                  rst_n,
  input  logic                                                  in_we,
  input  logic [((NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1)-1:0] in_addr,
  input  logic [PIXEL_BITS-1:0]                                 in_wdata,
  input  logic [3:0]                                            cfg_num_planes,
  input  logic                                                  start_pulse,
  input  logic                                                  step_done_pulse,
  output logic [NUM_INPUTS-1:0]                                 wl_bitmap,
  output logic                                                  wl_valid_pulse,
  output logic [((PIXEL_BITS > 1) ? $clog2(PIXEL_BITS) : 1)-1:0] plane_idx,
  output logic                                                  busy,
  output logic                                                  done_pulse,
  output logic                                                  timeout_pulse,
  output logic                                                  err_pulse
);

  localparam int AW   = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int PW   = (PIXEL_BITS > 1) ? $clog2(PIXEL_BITS) : 1;
  localparam int CW   = $clog2(PIXEL_BITS + 1);
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  enc_state_t            state_q, state_d;
  logic                  busy_q, busy_d;
  logic [NUM_INPUTS-1:0] wl_bitmap_q, wl_bitmap_d;
  logic                  wl_valid_q, wl_valid_d;
  logic [PW-1:0]         plane_idx_q, plane_idx_d;
  logic                  done_q, done_d;
  logic                  timeout_q, timeout_d;
  logic                  err_q, err_d;
  logic [CW-1:0]         n_q, n_d;
  logic [CW-1:0]         issued_q, issued_d;
  logic [WD_W-1:0]       wd_q, wd_d;

  logic                  w_buf_we;
  logic [PW-1:0]         w_plane_sel;
  logic [NUM_INPUTS-1:0] w_plane_bits;

  // Writes are legal only in IDLE and never alongside a start request
  assign w_buf_we = in_we && (state_q == ENC_IDLE) && !start_pulse;

  // Plane to be issued next: MSB when starting, otherwise one below current
  assign w_plane_sel = (state_q == ENC_IDLE) ? PW'(PIXEL_BITS - 1)
                                             : (plane_idx_q - 1'b1);

  input_pixel_buf #(
    .NUM_INPUTS (NUM_INPUTS),
    .PIXEL_BITS (PIXEL_BITS),
    .AW         (AW),
    .PW         (PW)
  ) u_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .we_i        (w_buf_we),
    .addr_i      (in_addr),
    .wdata_i     (in_wdata),
    .plane_sel_i (w_plane_sel),
    .bitmap_o    (w_plane_bits)
  );

  // State register and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ENC_IDLE;
      busy_q      <= 1'b0;
      wl_bitmap_q <= '0;
      wl_valid_q  <= 1'b0;
      plane_idx_q <= '0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      err_q       <= 1'b0;
      n_q         <= '0;
      issued_q    <= '0;
      wd_q        <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      wl_bitmap_q <= wl_bitmap_d;
      wl_valid_q  <= wl_valid_d;
      plane_idx_q <= plane_idx_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      err_q       <= err_d;
      n_q         <= n_d;
      issued_q    <= issued_d;
      wd_q        <= wd_d;
    end
  end

  // Next-state: frame sequencing, watchdog and illegal-request detection
  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    wl_bitmap_d = wl_bitmap_q;
    wl_valid_d  = 1'b0;
    plane_idx_d = plane_idx_q;
    done_d      = 1'b0;
    timeout_d   = 1'b0;
    err_d       = 1'b0;
    n_d         = n_q;
    issued_d    = issued_q;
    wd_d        = wd_q;

    // A write racing a start or arriving mid-frame is dropped and flagged,
    // as is any start while a frame is already running
    if (in_we && ((state_q == ENC_WAIT) || start_pulse)) begin
      err_d = 1'b1;
    end
    if (start_pulse && (state_q == ENC_WAIT)) begin
      err_d = 1'b1;
    end

    case (state_q)
      ENC_IDLE: begin
        if (start_pulse) begin
          if ((cfg_num_planes == 4'd0) || (int'(cfg_num_planes) > PIXEL_BITS)) begin
            n_d = CW'(PIXEL_BITS);
          end else begin
            n_d = CW'(cfg_num_planes);
          end
          issued_d    = CW'(1);
          plane_idx_d = w_plane_sel;
          wl_bitmap_d = w_plane_bits;
          wl_valid_d  = 1'b1;
          busy_d      = 1'b1;
          wd_d        = '0;
          state_d     = ENC_WAIT;
        end
      end

      ENC_WAIT: begin
        if (step_done_pulse) begin
          if (issued_q < n_q) begin
            issued_d    = issued_q + 1'b1;
            plane_idx_d = w_plane_sel;
            wl_bitmap_d = w_plane_bits;
            wl_valid_d  = 1'b1;
            wd_d        = '0;
          end else begin
            done_d      = 1'b1;
            busy_d      = 1'b0;
            plane_idx_d = '0;
            state_d     = ENC_IDLE;
          end
        end else if (TIMEOUT_CYCLES != 0) begin
          if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
            timeout_d   = 1'b1;
            busy_d      = 1'b0;
            plane_idx_d = '0;
            wd_d        = '0;
            state_d     = ENC_IDLE;
          end else begin
            wd_d = wd_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = ENC_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign wl_bitmap      = wl_bitmap_q;
  assign wl_valid_pulse = wl_valid_q;
  assign plane_idx      = plane_idx_q;
  assign busy           = busy_q;
  assign done_pulse     = done_q;
  assign timeout_pulse  = timeout_q;
  assign err_pulse      = err_q;

endmodule : bitplane_encoder
`default_nettype wire

// File: tb/tb_bitplane_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_bitplane_encoder
// Description : Self-checking bench for bitplane_encoder with a behavioural
//               pixel/plane reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bitplane_encoder;

  localparam int N  = snn_soc_pkg::NUM_INPUTS;
  localparam int PB = snn_soc_pkg::PIXEL_BITS;
  localparam int TO = 16;
  localparam int AW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = (PB > 1) ? $clog2(PB) : 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_we = 1'b0;
  logic [AW-1:0] in_addr = '0;
  logic [PB-1:0] in_wdata = '0;
  logic [3:0]    cfg_num_planes = 4'd8;
  logic          start_pulse = 1'b0;
  logic          step_done_pulse = 1'b0;
  logic [N-1:0]  wl_bitmap;
  logic          wl_valid_pulse;
  logic [PW-1:0] plane_idx;
  logic          busy;
  logic          done_pulse;
  logic          timeout_pulse;
  logic          err_pulse;

  int checks = 0;
  int errors = 0;
  int ref_buf [N];

  bitplane_encoder #(
    .NUM_INPUTS     (N),
    .PIXEL_BITS     (PB),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_we           (in_we),
    .in_addr         (in_addr),
    .in_wdata        (in_wdata),
    .cfg_num_planes  (cfg_num_planes),
    .start_pulse     (start_pulse),
    .step_done_pulse (step_done_pulse),
    .wl_bitmap       (wl_bitmap),
    .wl_valid_pulse  (wl_valid_pulse),
    .plane_idx       (plane_idx),
    .busy            (busy),
    .done_pulse      (done_pulse),
    .timeout_pulse   (timeout_pulse),
    .err_pulse       (err_pulse)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference plane: bit p of every pixel, straight from the stored values
  function automatic logic [N-1:0] model_plane(input int p);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = ((ref_buf[i] >> p) % 2) == 1;
    return r;
  endfunction

  function automatic int model_planes(input int cfg);
    return (cfg == 0 || cfg > PB) ? PB : cfg;
  endfunction

  task automatic write_pixel(input int addr, input int data);
    in_we = 1'b1; in_addr = AW'(addr); in_wdata = PB'(data);
    tick();
    in_we = 1'b0;
    if (addr < N) ref_buf[addr] = data % (1 << PB);
  endtask

  task automatic start_frame(input int cfg);
    cfg_num_planes = 4'(cfg);
    start_pulse = 1'b1;
    tick();
    start_pulse = 1'b0;
  endtask

  task automatic expect_issue(input int p);
    check($sformatf("valid_p%0d", p), 64'(wl_valid_pulse), 64'd1);
    check($sformatf("plane_idx_p%0d", p), 64'(plane_idx), 64'(p));
    check($sformatf("bitmap_p%0d", p), 64'(wl_bitmap), 64'(model_plane(p)));
    check($sformatf("busy_p%0d", p), 64'(busy), 64'd1);
  endtask

  // Answer the current step after `delay` idle cycles
  task automatic step(input int delay);
    for (int d = 0; d < delay; d++) begin
      tick();
      check("valid_between_steps", 64'(wl_valid_pulse), 64'd0);
    end
    step_done_pulse = 1'b1;
    tick();
    step_done_pulse = 1'b0;
  endtask

  // Starting in the issue cycle of plane index first_j, walk to done
  task automatic walk_frame(input int n, input int delay, input int first_j);
    for (int j = first_j; j < n; j++) begin
      expect_issue(PB - 1 - j);
      step(delay);
    end
    check("done_pulse", 64'(done_pulse), 64'd1);
    check("busy_after_done", 64'(busy), 64'd0);
    check("plane_idx_after_done", 64'(plane_idx), 64'd0);
    check("valid_at_done", 64'(wl_valid_pulse), 64'd0);
    check("timeout_at_done", 64'(timeout_pulse), 64'd0);
    tick();
    check("done_one_cycle", 64'(done_pulse), 64'd0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < N; i++) ref_buf[i] = 0;

    // Reset state
    tick(); tick();
    check("rst_bitmap", 64'(wl_bitmap), 64'd0);
    check("rst_valid", 64'(wl_valid_pulse), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_plane_idx", 64'(plane_idx), 64'd0);
    check("rst_done", 64'(done_pulse), 64'd0);
    check("rst_timeout", 64'(timeout_pulse), 64'd0);
    check("rst_err", 64'(err_pulse), 64'd0);
    rst_n = 1'b1;
    tick();

    // Single-plane issue then full frame with step_done 3 cycles after issue
    write_pixel(0, 8'h80);
    write_pixel(1, 8'h01);
    check("legal_write_no_err", 64'(err_pulse), 64'd0);
    start_frame(8);
    walk_frame(8, 3, 0);

    // Clamp and truncation
    start_frame(3);  walk_frame(3, 1, 0);
    start_frame(0);  walk_frame(8, 0, 0);
    start_frame(12); walk_frame(8, 2, 0);

    // step_done while idle is ignored
    step_done_pulse = 1'b1; tick(); step_done_pulse = 1'b0;
    tick();
    check("idle_step_valid", 64'(wl_valid_pulse), 64'd0);
    check("idle_step_busy", 64'(busy), 64'd0);
    check("idle_step_err", 64'(err_pulse), 64'd0);

    // Randomised frames against the model
    for (int f = 0; f < 8; f++) begin
      int cfg;
      for (int w = 0; w < 4; w++) write_pixel($urandom_range(0, N - 1), $urandom_range(0, 255));
      cfg = $urandom_range(0, 15);
      start_frame(cfg);
      walk_frame(model_planes(cfg), $urandom_range(0, 4), 0);
    end

    // Watchdog expiry: no step_done at all
    start_frame(8);
    expect_issue(PB - 1);
    for (int c = 1; c < TO; c++) tick();
    check("wd_not_yet", 64'(timeout_pulse), 64'd0);
    check("wd_busy_before", 64'(busy), 64'd1);
    tick();
    check("wd_timeout", 64'(timeout_pulse), 64'd1);
    check("wd_busy_cleared", 64'(busy), 64'd0);
    check("wd_no_done", 64'(done_pulse), 64'd0);
    tick();
    check("wd_one_cycle", 64'(timeout_pulse), 64'd0);
    start_frame(4);
    walk_frame(4, 1, 0);

    // step_done in the expiry cycle wins over the watchdog
    start_frame(1);
    expect_issue(PB - 1);
    for (int c = 1; c < TO; c++) tick();
    step_done_pulse = 1'b1; tick(); step_done_pulse = 1'b0;
    check("expiry_no_timeout", 64'(timeout_pulse), 64'd0);
    check("expiry_done", 64'(done_pulse), 64'd1);

    // Illegal requests mid-frame
    start_frame(8);
    expect_issue(PB - 1);
    in_we = 1'b1; in_addr = '0; in_wdata = 8'h5A;
    tick();
    in_we = 1'b0;
    check("err_write_busy", 64'(err_pulse), 64'd1);
    start_pulse = 1'b1;
    tick();
    start_pulse = 1'b0;
    check("err_start_busy", 64'(err_pulse), 64'd1);
    check("start_busy_no_issue", 64'(wl_valid_pulse), 64'd0);
    check("start_busy_plane", 64'(plane_idx), 64'(PB - 1));
    step_done_pulse = 1'b1; tick(); step_done_pulse = 1'b0;
    walk_frame(8, 1, 1);

    // Write coincident with start: frame starts, write dropped
    in_we = 1'b1; in_addr = AW'(2); in_wdata = 8'hFF;
    cfg_num_planes = 4'd8;
    start_pulse = 1'b1;
    tick();
    in_we = 1'b0; start_pulse = 1'b0;
    check("err_write_with_start", 64'(err_pulse), 64'd1);
    walk_frame(8, 0, 0);

    // Reset during WAIT of plane 5
    write_pixel(3, 8'hE7);
    start_frame(8);
    expect_issue(7); step(1);
    expect_issue(6); step(1);
    expect_issue(5);
    rst_n = 1'b0;
    #1;
    check("mid_rst_bitmap", 64'(wl_bitmap), 64'd0);
    check("mid_rst_valid", 64'(wl_valid_pulse), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_plane", 64'(plane_idx), 64'd0);
    tick();
    check("mid_rst_done", 64'(done_pulse), 64'd0);
    check("mid_rst_timeout", 64'(timeout_pulse), 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) ref_buf[i] = 0;
    tick();
    start_frame(8);
    check("post_rst_zero_bitmap", 64'(wl_bitmap), 64'd0);
    walk_frame(8, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_bitplane_encoder
`default_nettype wire
